mux41_rr_arbiter: RTL and testbench
===================================

// Module: mux41_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares a 4:1 select datapath between four requesters.
//  Owns the select lines s1/s2 (s1 = MSB): 00 -> a, 01 -> b, 10 -> c, 11 -> d.
//  Issues a one-hot grant and a registered mux output with valid.
//  Bounds how long one owner holds the path with MAX_HOLD.
// PARAMETERS
//  DATA_W    1  width of each data input a..d and of output y
//  MAX_HOLD  8  max consecutive grant cycles for one owner while another requests (>=1)
// PORTS
//  clk      in   1       single clock; all state updates on posedge
//  rst      in   1       synchronous, active-high reset
//  req      in   4       request; req[0]..req[3] belong to a..d
//  a        in   DATA_W  data from requester 0
//  b        in   DATA_W  data from requester 1
//  c        in   DATA_W  data from requester 2
//  d        in   DATA_W  data from requester 3
//  grant    out  4       registered one-hot grant; all zero = idle
//  s1       out  1       select MSB, registered
//  s2       out  1       select LSB, registered
//  y        out  DATA_W  registered output of the selected input
//  y_valid  out  1       y holds data sampled during a granted cycle
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - grant=0, s1=s2=0, y=0, y_valid=0.
//   - state=IDLE, hold_cnt=0, last_owner=3, so the first pick starts at req[0].
//   - Reset overrides every other event, including mid-grant.
//  FSM states: IDLE and GRANT.
//   - IDLE -> GRANT when |req=1. Winner = first set req scanning from last_owner+1, mod 4.
//   - GRANT -> GRANT (same owner) while req[owner]=1 and no forced rotation.
//   - GRANT -> GRANT (new owner) when req[owner]=0 and another req is set.
//     The winner is picked by the same scan, with no idle gap.
//   - GRANT -> IDLE when req[owner]=0 and no other req is set. grant<=0.
//  Forced rotation:
//   - hold_cnt counts owner cycles. It resets to 0 on every new grant.
//   - If hold_cnt==MAX_HOLD-1 and any other req is set, the grant moves to the next requester.
//   - If no other req is set, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
//  Latency:
//   - req sampled at edge N -> grant and s1/s2 valid after edge N.
//   - Data sampled during the grant cycle -> y valid after edge N+1.
//  Output register:
//   - Every edge: y_valid<=|grant and y<=mux(a..d by current s1,s2).
//   - When grant=0, y holds its last value.
//  Select lines:
//   - s1/s2 update together with grant.
//   - In IDLE they park at the last owner's value (00 after reset).
//  Handshake:
//   - A requester holds req until granted and keeps it high for as long as it needs the path.
//   - Dropping req before grant is a legal withdrawal and leaves no state behind.
//   - last_owner updates on every new grant.
//  Invariants:
//   - grant is always one-hot or zero.
//   - When granted, grant[{s1,s2}]=1.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> grant=0000, s1s2=00, y=0, y_valid=0.
//  2. Single request: req=0100 and c=1 from cycle 0.
//     -> grant=0100 and s1s2=10 after edge 1; y=1 and y_valid=1 after edge 2.
//  3. Rotation: req=1111 held, MAX_HOLD=4.
//     -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001.
//  4. Release: owner 0 drops req while req[3]=1, req[1]=req[2]=0.
//     -> grant=1000 on the very next cycle, y_valid stays 1 with no gap.
//  5. Lone owner: req=0010 held 20 cycles.
//     -> grant stays 0010, no forced rotation, hold_cnt saturated.
//  6. Mid-grant reset: rst=1 while grant=0100 and req=1111.
//     -> all outputs zero next cycle; after rst drops, the first grant is 0001.

Source files
------------

// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - round-robin arbiter owning a registered 4:1 select datapath
// Hold limit forces rotation only while another requester is waiting.
module mux41_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [3:0]        grant,
  output logic              s1,
  output logic              s2,
  output logic [DATA_W-1:0] y,
  output logic              y_valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        sel_q, sel_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [3:0]        grant_q, grant_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              y_valid_q, y_valid_d;

  logic [1:0]        pick;
  logic [1:0]        idx;
  logic              pick_any;
  logic              others;
  logic              take;
  logic [DATA_W-1:0] mux_out;

  // Scan starts just after the last owner; the owner itself is tried last.
  always_comb begin
    pick     = owner_q;
    pick_any = 1'b0;
    idx      = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = owner_q + 2'(i);
      if (!pick_any && req[idx]) begin
        pick     = idx;
        pick_any = 1'b1;
      end
    end
    others = |(req & ~(4'b0001 << owner_q));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) take = 1'b1;
      end
      GRANT: begin
        if (!req[owner_q]) begin
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (hold_q == HOLD_LAST && others) begin
          take = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = GRANT;
      owner_d = pick;
      sel_d   = pick;
      hold_d  = '0;
      grant_d = 4'b0001 << pick;
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_out = a;
      2'd1:    mux_out = b;
      2'd2:    mux_out = c;
      default: mux_out = d;
    endcase
    y_valid_d = |grant_q;
    y_d       = (|grant_q) ? mux_out : y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 2'd3;
      sel_q     <= 2'd0;
      hold_q    <= '0;
      grant_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign grant   = grant_q;
  assign s1      = sel_q[1];
  assign s2      = sel_q[0];
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - directed scoreboard bench for mux41_rr_arbiter
module tb_mux41_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [0:0] a, b, c, d;
  logic [3:0] grant;
  logic       s1, s2;
  logic [0:0] y;
  logic       y_valid;

  mux41_rr_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .grant(grant), .s1(s1), .s2(s2), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       yv;
    logic       y;
  } exp_t;

  exp_t       exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] prev_g = '0;
  logic [1:0] prev_s = '0;
  logic       prev_y = 1'b0;

  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".grant"},   grant, e.g);
    chk({tag, ".sel"},     {2'b00, s1, s2}, {2'b00, e.s});
    chk({tag, ".y_valid"}, {3'b000, y_valid}, {3'b000, e.yv});
    chk({tag, ".y"},       {3'b000, y}, {3'b000, e.y});
    chk({tag, ".onehot"},  {3'b000, $onehot0(grant)}, 4'b0001);
    if (grant != 4'b0000)
      chk({tag, ".grant_at_sel"}, {3'b000, grant[{s1, s2}]}, 4'b0001);
    prev_g = e.g;
    prev_s = e.s;
    prev_y = e.y;
  endtask

  // dat bit i is the data of requester i for this cycle
  task automatic step(input logic [3:0] r, input logic [3:0] dat, input logic [3:0] eg, input string tag);
    exp_t e;
    rst = 1'b0;
    req = r;
    {d, c, b, a} = dat;
    e.g  = eg;
    e.s  = (eg != 4'b0000) ? enc(eg) : prev_s;
    e.yv = |prev_g;
    e.y  = (|prev_g) ? dat[prev_s] : prev_y;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check(tag);
  endtask

  task automatic reset_step(input logic [3:0] r, input string tag);
    exp_t e;
    rst = 1'b1;
    req = r;
    {d, c, b, a} = 4'b1111;
    e.g = '0; e.s = '0; e.yv = 1'b0; e.y = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check(tag);
  endtask

  initial begin
    logic [3:0] eg;
    rst = 1'b1;
    req = '0;
    {d, c, b, a} = '0;

    reset_step(4'b0000, "reset0");
    reset_step(4'b0000, "reset1");

    step(4'b0100, 4'b0100, 4'b0100, "single_grant");
    step(4'b0100, 4'b0100, 4'b0100, "single_data");
    step(4'b0000, 4'b0000, 4'b0000, "single_release");
    step(4'b0000, 4'b1111, 4'b0000, "idle_park");

    reset_step(4'b0000, "reset_rot");
    for (int i = 0; i < 17; i++) begin
      eg = 4'b0001 << ((i / 4) % 4);
      step(4'b1111, 4'($urandom_range(0, 15)), eg, $sformatf("rot%0d", i));
    end

    step(4'b1001, 4'b1001, 4'b0001, "release_hold");
    step(4'b1000, 4'b1000, 4'b1000, "release_switch");
    step(4'b1000, 4'b0000, 4'b1000, "release_keep");

    for (int i = 0; i < 20; i++)
      step(4'b0010, 4'($urandom_range(0, 15)), 4'b0010, $sformatf("lone%0d", i));
    step(4'b0011, 4'b0010, 4'b0001, "sat_rotate");

    step(4'b0100, 4'b0100, 4'b0100, "pre_rst_grant");
    step(4'b1111, 4'b0100, 4'b0100, "pre_rst_hold");
    reset_step(4'b1111, "mid_reset");
    step(4'b1111, 4'b0001, 4'b0001, "post_reset_first");
    step(4'b1111, 4'b0001, 4'b0001, "post_reset_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
